// File: rtl/kfsdram_pkg.sv
// Shared definitions for the KFSDRAM request interface and its BRAM-backed responder:
// interface widths, default SDRAM timing, responder state encoding and small helpers.
package kfsdram_pkg;

    localparam int REQ_ADDR_W = 25;
    localparam int REQ_NUM_W  = 10;
    localparam int REQ_DATA_W = 16;

    // One bit wider than access_num so a 1023-beat burst counts down cleanly.
    localparam int BEAT_W  = REQ_NUM_W + 1;
    localparam int TIMER_W = 8;

    localparam int DEF_MEM_ADDR_WIDTH = 15;
    localparam int DEF_T_RCD          = 2;
    localparam int DEF_CAS_LATENCY    = 2;
    localparam int DEF_T_RP           = 2;
    localparam int DEF_T_RFC          = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_WRITE,
        ST_CAS_WAIT,
        ST_READ,
        ST_PRECHARGE,
        ST_REFRESH
    } state_e;

    function automatic logic [BEAT_W-1:0] burst_len(input logic [REQ_NUM_W-1:0] num);
        return (num == '0) ? BEAT_W'(1) : BEAT_W'(num);
    endfunction

    // Phase timers count down to zero, so a phase of N cycles loads N-1.
    function automatic logic [TIMER_W-1:0] phase_load(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/kf_sync_ram.sv
// Single-port synchronous RAM with registered read (read-first) and write enable;
// written so synthesis maps it onto block RAM.
module kf_sync_ram #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/kfsdram_bram_responder.sv
// Responder for the KFSDRAM request interface served from on-chip block RAM; replays
// SDRAM phase timing (tRCD, CAS latency, tRP, tRFC) so initiator timing is unchanged.
module kfsdram_bram_responder
    import kfsdram_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int T_RCD          = DEF_T_RCD,
    parameter int CAS_LATENCY    = DEF_CAS_LATENCY,
    parameter int T_RP           = DEF_T_RP,
    parameter int T_RFC          = DEF_T_RFC
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REQ_ADDR_W-1:0] address,
    input  logic [REQ_NUM_W-1:0]  access_num,
    input  logic [REQ_DATA_W-1:0] data_in,
    output logic [REQ_DATA_W-1:0] data_out,
    input  logic                  write_request,
    input  logic                  read_request,
    input  logic                  enable_refresh,
    output logic                  write_flag,
    output logic                  read_flag,
    output logic                  idle,
    output logic                  refresh_mode
);

    state_e                    state_q, state_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [BEAT_W-1:0]         beats_q, beats_d;
    logic [MEM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                      is_write_q, is_write_d;
    logic                      pending_q, pending_d;
    logic [REQ_DATA_W-1:0]     dout_q, dout_d;

    logic                      refresh_req;
    logic                      ram_we;
    logic [MEM_ADDR_WIDTH-1:0] ram_addr;
    logic [REQ_DATA_W-1:0]     ram_rdata;
    logic                      addr_unused;

    // Upper address bits alias onto the smaller backing store.
    assign addr_unused = ^address[REQ_ADDR_W-1:MEM_ADDR_WIDTH];

    // A pulse on the accepting edge counts as pending, so it still beats a request.
    assign refresh_req = pending_q | enable_refresh;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        beats_d    = beats_q;
        ptr_d      = ptr_q;
        is_write_d = is_write_q;
        pending_d  = refresh_req;
        dout_d     = dout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (refresh_req) begin
                    state_d   = ST_REFRESH;
                    timer_d   = phase_load(T_RFC);
                    pending_d = 1'b0;
                end else if (write_request || read_request) begin
                    state_d    = ST_ACTIVE;
                    timer_d    = phase_load(T_RCD);
                    beats_d    = burst_len(access_num);
                    ptr_d      = address[MEM_ADDR_WIDTH-1:0];
                    is_write_d = write_request;
                end
            end
            ST_ACTIVE: begin
                if (timer_q == '0) begin
                    if (is_write_q) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_CAS_WAIT;
                        timer_d = phase_load(CAS_LATENCY);
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_CAS_WAIT: begin
                if (timer_q == '0) begin
                    state_d = ST_READ;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_WRITE, ST_READ: begin
                ptr_d   = ptr_q + 1'b1;
                beats_d = beats_q - 1'b1;
                if (state_q == ST_READ) begin
                    dout_d = ram_rdata;
                end
                if (beats_q == BEAT_W'(1)) begin
                    state_d = ST_PRECHARGE;
                    timer_d = phase_load(T_RP);
                end
            end
            ST_PRECHARGE, ST_REFRESH: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            beats_q    <= '0;
            ptr_q      <= '0;
            is_write_q <= 1'b0;
            pending_q  <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            beats_q    <= beats_d;
            ptr_q      <= ptr_d;
            is_write_q <= is_write_d;
            pending_q  <= pending_d;
            dout_q     <= dout_d;
        end
    end

    // Reads address the next-cycle pointer so the registered RAM output lines up
    // with the read_flag cycle; writes go to the current pointer.
    assign ram_we   = (state_q == ST_WRITE);
    assign ram_addr = (state_q == ST_WRITE) ? ptr_q : ptr_d;

    kf_sync_ram #(
        .ADDR_W (MEM_ADDR_WIDTH),
        .DATA_W (REQ_DATA_W)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (data_in),
        .rdata_o (ram_rdata)
    );

    assign write_flag   = (state_q == ST_WRITE);
    assign read_flag    = (state_q == ST_READ);
    assign refresh_mode = (state_q == ST_REFRESH);
    assign idle         = (state_q == ST_IDLE) && !pending_q;
    assign data_out     = read_flag ? ram_rdata : dout_q;

`ifndef SYNTHESIS
    a_flags_exclusive: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0({write_flag, read_flag, refresh_mode}));
`endif

endmodule

// File: tb/tb_kfsdram_bram_responder.sv
// Randomised and directed bench for kfsdram_bram_responder with a cycle-schedule
// reference model of the SDRAM-style access phases and a sparse memory image.
module tb_kfsdram_bram_responder;

    localparam int AW    = 15;
    localparam int T_RCD = 2;
    localparam int CAS   = 2;
    localparam int T_RP  = 2;
    localparam int T_RFC = 7;

    localparam logic [2:0] K_IDLE = 3'd0;
    localparam logic [2:0] K_BUSY = 3'd1;
    localparam logic [2:0] K_WR   = 3'd2;
    localparam logic [2:0] K_RD   = 3'd3;
    localparam logic [2:0] K_REF  = 3'd4;

    typedef struct packed {
        logic [2:0]    kind;
        logic [AW-1:0] addr;
    } slot_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [24:0] address = '0;
    logic [9:0]  access_num = '0;
    logic [15:0] data_in = '0;
    logic        write_request = 1'b0;
    logic        read_request = 1'b0;
    logic        enable_refresh = 1'b0;
    logic [15:0] data_out;
    logic        write_flag;
    logic        read_flag;
    logic        idle;
    logic        refresh_mode;

    int checks = 0;
    int errors = 0;

    slot_t       sched[$];
    slot_t       cur = '0;
    bit          pend = 1'b0;
    logic [15:0] mem_m [int];
    logic [15:0] last_dout = '0;
    bit          last_known = 1'b1;

    logic [15:0] din_plan [0:31];
    logic        ref_plan [0:31];
    logic        wf_h [0:31];
    logic        rf_h [0:31];
    logic        rm_h [0:31];
    logic        id_h [0:31];
    logic [15:0] do_h [0:31];

    kfsdram_bram_responder dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .address        (address),
        .access_num     (access_num),
        .data_in        (data_in),
        .data_out       (data_out),
        .write_request  (write_request),
        .read_request   (read_request),
        .enable_refresh (enable_refresh),
        .write_flag     (write_flag),
        .read_flag      (read_flag),
        .idle           (idle),
        .refresh_mode   (refresh_mode)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_n(input logic [2:0] kind, input int n);
        slot_t s;
        s.kind = kind;
        s.addr = '0;
        for (int i = 0; i < n; i++) sched.push_back(s);
    endtask

    // An accepted access is a fixed sequence of cycles: row open, optional CAS wait,
    // one cycle per word, then precharge.
    task automatic push_burst(input bit wr, input logic [24:0] a, input logic [9:0] num);
        int    n;
        slot_t s;
        n = (num == 10'd0) ? 1 : int'(num);
        push_n(K_BUSY, wr ? T_RCD : T_RCD + CAS);
        for (int i = 0; i < n; i++) begin
            s.kind = wr ? K_WR : K_RD;
            s.addr = AW'((int'(a) + i) % (1 << AW));
            sched.push_back(s);
        end
        push_n(K_BUSY, T_RP);
    endtask

    always @(negedge clock) begin
        logic [3:0] exp_f;
        if (!reset_n) begin
            sched.delete();
            cur        = '0;
            pend       = 1'b0;
            last_dout  = '0;
            last_known = 1'b1;
            check("reset_flags{wr,rd,ref,idle}",
                  32'({write_flag, read_flag, refresh_mode, idle}), 32'(4'b0001));
            check("reset_data_out", 32'(data_out), 32'h0);
        end else begin
            exp_f = {cur.kind == K_WR, cur.kind == K_RD, cur.kind == K_REF,
                     (cur.kind == K_IDLE) && !pend};
            check("flags{wr,rd,ref,idle}",
                  32'({write_flag, read_flag, refresh_mode, idle}), 32'(exp_f));
            if (cur.kind == K_WR) mem_m[int'(cur.addr)] = data_in;
            if (cur.kind == K_RD) begin
                if (mem_m.exists(int'(cur.addr))) begin
                    last_dout  = mem_m[int'(cur.addr)];
                    last_known = 1'b1;
                end else begin
                    last_known = 1'b0;
                end
            end
            if (last_known) check("data_out", 32'(data_out), 32'(last_dout));

            if (cur.kind == K_IDLE) begin
                if (pend || enable_refresh) begin
                    push_n(K_REF, T_RFC);
                    pend = 1'b0;
                end else if (write_request) begin
                    push_burst(1'b1, address, access_num);
                end else if (read_request) begin
                    push_burst(1'b0, address, access_num);
                end
            end else if (enable_refresh) begin
                pend = 1'b1;
            end
            cur = (sched.size() != 0) ? sched.pop_front() : slot_t'(0);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (1) begin
            data_in = 16'($urandom);
            @(negedge clock);
            if (idle) break;
            n++;
            if (n > 2500) begin
                checks++;
                errors++;
                $display("FAIL wait_idle: idle still 0 after %0d cycles, required 1", n);
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    task automatic issue(input bit wr, input logic [24:0] a, input logic [9:0] n);
        address       = a;
        access_num    = n;
        write_request = wr;
        read_request  = !wr;
        @(posedge clock); #1;
        write_request = 1'b0;
        read_request  = 1'b0;
    endtask

    task automatic set_plan(input logic [15:0] d);
        for (int k = 0; k < 32; k++) begin
            din_plan[k] = d;
            ref_plan[k] = 1'b0;
        end
    endtask

    task automatic observe(input int n);
        for (int k = 1; k <= n; k++) begin
            data_in        = din_plan[k];
            enable_refresh = ref_plan[k];
            @(negedge clock);
            wf_h[k] = write_flag;
            rf_h[k] = read_flag;
            rm_h[k] = refresh_mode;
            id_h[k] = idle;
            do_h[k] = data_out;
            @(posedge clock); #1;
        end
        enable_refresh = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int fr;
        int fw;
        int fd;
        int cnt;
        bit drop_wr;
        set_plan(16'h0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Refresh pulse: seven refresh cycles, then idle.
        wait_idle();
        enable_refresh = 1'b1;
        @(posedge clock); #1;
        enable_refresh = 1'b0;
        observe(9);
        for (int k = 1; k <= 8; k++)
            check($sformatf("ref_mode_c%0d", k), 32'(rm_h[k]), 32'(k <= 7));
        check("ref_idle_after", 32'(id_h[8]), 32'd1);

        // Single write, then single read of the same word.
        set_plan(16'h0123);
        wait_idle();
        issue(1'b1, 25'h00100, 10'd1);
        observe(8);
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("wr1_flag_c%0d", k), 32'(wf_h[k]), 32'(k == 3));
            check($sformatf("wr1_idle_c%0d", k), 32'(id_h[k]), 32'(k >= 6));
        end
        set_plan(16'h0);
        wait_idle();
        issue(1'b0, 25'h00100, 10'd1);
        observe(8);
        for (int k = 1; k <= 8; k++)
            check($sformatf("rd1_flag_c%0d", k), 32'(rf_h[k]), 32'(k == 5));
        check("rd1_data", 32'(do_h[5]), 32'h0123);
        check("rd1_hold", 32'(do_h[8]), 32'h0123);
        check("rd1_idle_c8", 32'(id_h[8]), 32'd1);

        // Aliased upper address bits and access_num = 0.
        wait_idle();
        issue(1'b0, 25'h1000100, 10'd0);
        observe(8);
        cnt = 0;
        for (int k = 1; k <= 8; k++) cnt += int'(rf_h[k]);
        check("alias_num0_beats", 32'(cnt), 32'd1);
        check("alias_data", 32'(do_h[5]), 32'h0123);

        // Burst across the top of memory.
        set_plan(16'h0);
        for (int k = 3; k <= 6; k++) din_plan[k] = 16'(16'hA0 + k - 3);
        wait_idle();
        issue(1'b1, 25'h07FFE, 10'd4);
        observe(10);
        for (int k = 1; k <= 9; k++)
            check($sformatf("wrap_wr_flag_c%0d", k), 32'(wf_h[k]), 32'((k >= 3) && (k <= 6)));
        set_plan(16'h0);
        wait_idle();
        issue(1'b0, 25'h07FFE, 10'd4);
        observe(12);
        for (int k = 5; k <= 8; k++) begin
            check($sformatf("wrap_rd_flag_c%0d", k), 32'(rf_h[k]), 32'd1);
            check($sformatf("wrap_rd_data_c%0d", k), 32'(do_h[k]), 32'(16'hA0 + k - 5));
        end
        wait_idle();
        issue(1'b0, 25'h00000, 10'd2);
        observe(8);
        check("wrap_low_w0", 32'(do_h[5]), 32'h00A2);
        check("wrap_low_w1", 32'(do_h[6]), 32'h00A3);

        // Write, read and refresh together: refresh, then write, then read once re-sampled.
        wait_idle();
        address        = 25'h00200;
        access_num     = 10'd1;
        data_in        = 16'h5A5A;
        write_request  = 1'b1;
        read_request   = 1'b1;
        enable_refresh = 1'b1;
        @(posedge clock); #1;
        enable_refresh = 1'b0;
        fr = 0; fw = 0; fd = 0; drop_wr = 1'b0;
        for (int k = 1; k <= 40 && fd == 0; k++) begin
            data_in = 16'h5A5A;
            @(negedge clock);
            if (refresh_mode && fr == 0) fr = k;
            if (write_flag && fw == 0) begin fw = k; drop_wr = 1'b1; end
            if (read_flag && fd == 0) begin
                fd = k;
                check("simul_rd_data", 32'(data_out), 32'h5A5A);
            end
            @(posedge clock); #1;
            if (drop_wr) write_request = 1'b0;
        end
        write_request = 1'b0;
        read_request  = 1'b0;
        check("simul_first_ref", 32'(fr), 32'd1);
        check("simul_first_wr", 32'(fw), 32'd11);
        check("simul_first_rd", 32'(fd), 32'd19);

        // Read of three with the request dropped right after acceptance.
        set_plan(16'h0);
        wait_idle();
        issue(1'b0, 25'h07FFE, 10'd3);
        observe(12);
        cnt = 0;
        for (int k = 1; k <= 12; k++) cnt += int'(rf_h[k]);
        check("rd3_beats", 32'(cnt), 32'd3);
        check("rd3_last_data", 32'(do_h[7]), 32'h00A2);
        check("rd3_idle_c10", 32'(id_h[10]), 32'd1);

        // Refresh pulse in mid burst is held until the following idle.
        set_plan(16'h0033);
        ref_plan[4] = 1'b1;
        wait_idle();
        issue(1'b1, 25'h00300, 10'd4);
        observe(18);
        cnt = 0;
        for (int k = 1; k <= 18; k++) cnt += int'(wf_h[k]);
        check("refburst_beats", 32'(cnt), 32'd4);
        check("refburst_idle_c9", 32'(id_h[9]), 32'd0);
        check("refburst_ref_c9", 32'(rm_h[9]), 32'd0);
        check("refburst_ref_c10", 32'(rm_h[10]), 32'd1);
        check("refburst_ref_c16", 32'(rm_h[16]), 32'd1);
        check("refburst_idle_c17", 32'(id_h[17]), 32'd1);

        // Reset in the middle of a write burst keeps the words already written.
        set_plan(16'h0077);
        wait_idle();
        issue(1'b1, 25'h00400, 10'd8);
        observe(5);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_outputs", 32'({write_flag, read_flag, refresh_mode, idle}), 32'(4'b0001));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        set_plan(16'h0);
        wait_idle();
        issue(1'b0, 25'h00400, 10'd3);
        observe(9);
        for (int k = 5; k <= 7; k++)
            check($sformatf("midrst_kept_c%0d", k), 32'(do_h[k]), 32'h0077);

        // Longest burst, written with random data and read back.
        wait_idle();
        issue(1'b1, 25'h00010, 10'd1023);
        wait_idle();
        issue(1'b0, 25'h00010, 10'd1023);
        wait_idle();

        // Random traffic, with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            reset_n        = !((i == 1500) || (i == 1501));
            write_request  = ($urandom_range(0, 5) == 0);
            read_request   = ($urandom_range(0, 5) == 0);
            enable_refresh = ($urandom_range(0, 29) == 0);
            address        = 25'((($urandom_range(0, 3)) << 15) |
                                 (($urandom_range(0, 1) != 0 ? 32'h7FF8 : 32'h0) +
                                  $urandom_range(0, 15)));
            access_num     = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 8));
            data_in        = 16'($urandom);
            @(posedge clock); #1;
        end
        reset_n        = 1'b1;
        write_request  = 1'b0;
        read_request   = 1'b0;
        enable_refresh = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
